icache_refill_ctrl: RTL and testbench
=====================================

# icache_refill_ctrl

Sequences L1 instruction-cache miss handling for the fetch unit. It watches the fetch stage's `miss_o`/`missAddr_o`, issues one block-aligned read request to the lower memory level, and collects the multi-beat response into a full cache block. It then drives the fetch stage's `wrEnable_i`/`wrAddr_i`/`instBlock_i` fill port for exactly one cycle. It sits between the fetch stage and the L2/memory interface and handles one outstanding miss at a time.

## Interface
- `SIZE_PC`, 32: PC/address width.
- `CACHE_WIDTH`, 256: cache block width in bits (4 instructions × 64 b).
- `MEM_WIDTH`, 64: memory response beat width; `CACHE_WIDTH` must be an integer multiple of it.
- `BLOCK_BYTES`, 32: block size in bytes; a power of two.
- Derived: `BEATS = CACHE_WIDTH/MEM_WIDTH` (4 by default); the beat counter width is `clog2(BEATS)`, minimum 1.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `miss_i` in 1: cache miss reported by the fetch stage.
- `missAddr_i` in SIZE_PC: PC that missed.
- `memReqValid_o` out 1: read request valid.
- `memReqReady_i` in 1: memory accepts the request.
- `memReqAddr_o` out SIZE_PC: block-aligned request address.
- `memRespValid_i` in 1: one response beat is valid.
- `memRespData_i` in MEM_WIDTH: response beat data.
- `wrEnable_o` out 1: cache fill strobe.
- `wrAddr_o` out SIZE_PC: fill address, block-aligned.
- `instBlock_o` out CACHE_WIDTH: assembled block.
- `busy_o` out 1: high in any state other than IDLE.
- `protoErr_o` out 1: sticky; set when a beat arrives outside FILL. Cleared only by reset.

## Operation
- States: IDLE, REQ, FILL, WRITE, SETTLE.
- **IDLE**
  - If `miss_i`=1, latch `missAddr_i & ~(BLOCK_BYTES-1)` into the address register, clear the beat counter, and go to REQ.
- **REQ**
  - `memReqValid_o`=1 and `memReqAddr_o` = latched address, both held stable until `memReqReady_i`=1.
  - On handshake, go to FILL.
  - `memRespValid_i` in REQ, including the handshake cycle, is a protocol error. Set `protoErr_o` and ignore the beat.
- **FILL**
  - Each cycle with `memRespValid_i`=1, write beat k into `instBlock_o[k*MEM_WIDTH +: MEM_WIDTH]` (beat 0 = lowest bits), then increment k.
  - When beat `BEATS-1` is accepted, go to WRITE. There is no backpressure on responses.
- **WRITE**
  - `wrEnable_o`=1 for exactly this one cycle.
  - `wrAddr_o` = latched address; `instBlock_o` is complete.
  - Go to SETTLE.
- **SETTLE**
  - One cycle in which `miss_i` is ignored, so the cache can re-look-up after the fill.
  - Go to IDLE.
- Fetch redirects or flushes do not abort a refill. The fetched block is valid data and is always written.
- `memRespValid_i` in IDLE, WRITE or SETTLE sets `protoErr_o`. The beat is discarded and the state is unchanged.
- `instBlock_o` and `wrAddr_o` hold their last values outside WRITE. Only `wrEnable_o` qualifies them.

## Timing
- Reset values: state=IDLE, and `memReqValid_o`, `memReqAddr_o`, `wrEnable_o`, `wrAddr_o`, `instBlock_o`, `busy_o`, `protoErr_o` all 0; beat counter 0.
- Reset asserted in any state: all of the above take effect at the next edge. Outstanding beats are not tracked after reset; subsequent beats in IDLE set `protoErr_o`.
- Miss at edge t (IDLE sampling `miss_i`=1): `memReqValid_o`=1 from cycle t+1.
- With ready at t+1 and beats on consecutive cycles t+2..t+2+BEATS-1:
  - `wrEnable_o`=1 in cycle t+2+BEATS (t+6 with defaults).
  - SETTLE in t+7; IDLE in t+8, where a new miss can be sampled.
- Minimum miss-to-fill latency is 1 + 1 + BEATS cycles. Gaps between beats extend FILL by exactly the gap length.
- All outputs are registered, with no combinational input-to-output paths.
- `busy_o` is 1 from the cycle after the miss is sampled through SETTLE inclusive.

## Test plan
1. **Basic refill**
   - Stimulus: reset, then `miss_i`=1 with `missAddr_i`=0x0000_1234; ready immediately; beats 0x11.., 0x22.., 0x33.., 0x44.. on consecutive cycles.
   - Required response: `memReqAddr_o`=0x0000_1220; one-cycle `wrEnable_o` with `wrAddr_o`=0x1220 and `instBlock_o`={0x44..,0x33..,0x22..,0x11..}; wrEnable asserted 6 cycles after the miss sample.
2. **Request backpressure**
   - Stimulus: `memReqReady_i` held low for 5 cycles.
   - Required response: `memReqValid_o` and address stable all 5 cycles; exactly one handshake; fill completes normally.
3. **Gapped beats**
   - Stimulus: beats separated by 0, 2, 0 and 3 idle cycles.
   - Required response: correct beat ordering in `instBlock_o`; `wrEnable_o` 5 cycles later than in scenario 1.
4. **Miss held high**
   - Stimulus: `miss_i` held at 1 throughout and after the fill.
   - Required response: exactly one request per pass; no new request is sampled during SETTLE; the second request is issued only after IDLE is re-entered.
5. **Protocol error**
   - Stimulus: `memRespValid_i` pulsed in IDLE.
   - Required response: `protoErr_o`=1 and stays 1; no fill; a subsequent miss still refills correctly.
6. **Reset mid-refill**
   - Stimulus: reset asserted after 2 of 4 beats, then a new miss to 0x40.
   - Required response: all outputs 0 after the edge; no `wrEnable_o` for the old block; a clean refill of block 0x40.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// icache_refill_ctrl : L1 I-cache miss refill sequencer (one outstanding miss)
// Revision 1.0
// ============================================================================
module icache_refill_ctrl #(
  parameter int SIZE_PC     = 32,
  parameter int CACHE_WIDTH = 256,
  parameter int MEM_WIDTH   = 64,
  parameter int BLOCK_BYTES = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss_i,
  input  logic [SIZE_PC-1:0]     missAddr_i,
  output logic                   memReqValid_o,
  input  logic                   memReqReady_i,
  output logic [SIZE_PC-1:0]     memReqAddr_o,
  input  logic                   memRespValid_i,
  input  logic [MEM_WIDTH-1:0]   memRespData_i,
  output logic                   wrEnable_o,
  output logic [SIZE_PC-1:0]     wrAddr_o,
  output logic [CACHE_WIDTH-1:0] instBlock_o,
  output logic                   busy_o,
  output logic                   protoErr_o
);

  localparam int BEATS  = CACHE_WIDTH / MEM_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]  C_LAST_BEAT   = BEAT_W'(BEATS - 1);
  localparam logic [SIZE_PC-1:0] C_OFFSET_MASK = SIZE_PC'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_FILL   = 3'd2,
    S_WRITE  = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_nextState;
  logic [SIZE_PC-1:0]       r_reqAddr;
  logic [BEAT_W-1:0]        r_beatCnt;
  logic [CACHE_WIDTH-1:0]   r_fillBuf;
  logic [CACHE_WIDTH-1:0]   w_mergedBlock;
  logic [SIZE_PC-1:0]       r_wrAddr;
  logic [CACHE_WIDTH-1:0]   r_instBlock;
  logic                     r_reqValid;
  logic                     r_wrEnable;
  logic                     r_busy;
  logic                     r_protoErr;
  logic                     w_beatAccept;
  logic                     w_lastBeat;

  assign w_beatAccept = (r_state == S_FILL) && memRespValid_i;
  assign w_lastBeat   = w_beatAccept && (r_beatCnt == C_LAST_BEAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (miss_i)        w_nextState = S_REQ;
      S_REQ:    if (memReqReady_i) w_nextState = S_FILL;
      S_FILL:   if (w_lastBeat)    w_nextState = S_WRITE;
      S_WRITE:  w_nextState = S_SETTLE;
      S_SETTLE: w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Current fill buffer with the incoming beat dropped into its slot.
  always_comb begin
    w_mergedBlock = r_fillBuf;
    for (int k = 0; k < BEATS; k++) begin
      if (r_beatCnt == BEAT_W'(k)) begin
        w_mergedBlock[k*MEM_WIDTH +: MEM_WIDTH] = memRespData_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reqAddr   <= '0;
      r_beatCnt   <= '0;
      r_fillBuf   <= '0;
      r_wrAddr    <= '0;
      r_instBlock <= '0;
      r_reqValid  <= 1'b0;
      r_wrEnable  <= 1'b0;
      r_busy      <= 1'b0;
      r_protoErr  <= 1'b0;
    end else begin
      r_reqValid <= (w_nextState == S_REQ);
      r_wrEnable <= (w_nextState == S_WRITE);
      r_busy     <= (w_nextState != S_IDLE);

      if ((r_state == S_IDLE) && miss_i) begin
        r_reqAddr <= missAddr_i & ~C_OFFSET_MASK;
        r_beatCnt <= '0;
      end

      if (w_beatAccept) begin
        r_fillBuf <= w_mergedBlock;
        r_beatCnt <= r_beatCnt + BEAT_W'(1);
      end

      // Fill port is only updated as WRITE is entered, so it holds otherwise.
      if (w_lastBeat) begin
        r_instBlock <= w_mergedBlock;
        r_wrAddr    <= r_reqAddr;
      end

      if (memRespValid_i && (r_state != S_FILL)) begin
        r_protoErr <= 1'b1;
      end
    end
  end

  assign memReqValid_o = r_reqValid;
  assign memReqAddr_o  = r_reqAddr;
  assign wrEnable_o    = r_wrEnable;
  assign wrAddr_o      = r_wrAddr;
  assign instBlock_o   = r_instBlock;
  assign busy_o        = r_busy;
  assign protoErr_o    = r_protoErr;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// tb_icache_refill_ctrl : self-checking bench for icache_refill_ctrl
// Revision 1.0
// ============================================================================
module tb_icache_refill_ctrl;

  logic         clk;
  logic         reset;
  logic         miss_i;
  logic [31:0]  missAddr_i;
  logic         memReqValid_o;
  logic         memReqReady_i;
  logic [31:0]  memReqAddr_o;
  logic         memRespValid_i;
  logic [63:0]  memRespData_i;
  logic         wrEnable_o;
  logic [31:0]  wrAddr_o;
  logic [255:0] instBlock_o;
  logic         busy_o;
  logic         protoErr_o;

  icache_refill_ctrl #(
    .SIZE_PC(32), .CACHE_WIDTH(256), .MEM_WIDTH(64), .BLOCK_BYTES(32)
  ) dut (
    .clk(clk), .reset(reset), .miss_i(miss_i), .missAddr_i(missAddr_i),
    .memReqValid_o(memReqValid_o), .memReqReady_i(memReqReady_i),
    .memReqAddr_o(memReqAddr_o), .memRespValid_i(memRespValid_i),
    .memRespData_i(memRespData_i), .wrEnable_o(wrEnable_o),
    .wrAddr_o(wrAddr_o), .instBlock_o(instBlock_o), .busy_o(busy_o),
    .protoErr_o(protoErr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hsCount = 0;
  int wrCount = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: handshakes and fill strobes seen mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (memReqValid_o && memReqReady_i) hsCount <= hsCount + 1;
      if (wrEnable_o) wrCount <= wrCount + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          gapsA[4];
  logic [63:0] dataA[4];

  // One complete refill; expectations (aligned address, latency) come from the caller.
  task automatic doRefill(input logic [31:0] addr, input logic [31:0] expAddr,
                          input int rdyDly, input int expLat, input bit holdMiss);
    int hs0, wr0, t;
    logic [255:0] expBlk;
    expBlk = {dataA[3], dataA[2], dataA[1], dataA[0]};
    hs0 = hsCount;
    wr0 = wrCount;
    miss_i = 1'b1;
    missAddr_i = addr;
    t = cyc;
    tick();
    if (!holdMiss) miss_i = 1'b0;
    missAddr_i = $urandom;
    for (int i = 0; i < rdyDly; i++) begin
      chk("reqValid_stall", {255'b0, memReqValid_o}, 256'd1);
      chk("reqAddr_stall", {224'b0, memReqAddr_o}, {224'b0, expAddr});
      tick();
    end
    memReqReady_i = 1'b1;
    chk("reqValid", {255'b0, memReqValid_o}, 256'd1);
    chk("reqAddr", {224'b0, memReqAddr_o}, {224'b0, expAddr});
    tick();
    memReqReady_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gapsA[k]; g++) tick();
      memRespValid_i = 1'b1;
      memRespData_i = dataA[k];
      tick();
      memRespValid_i = 1'b0;
      memRespData_i = {$urandom, $urandom};
    end
    chk("wrEnable", {255'b0, wrEnable_o}, 256'd1);
    chk("wrAddr", {224'b0, wrAddr_o}, {224'b0, expAddr});
    chk("instBlock", instBlock_o, expBlk);
    chk("latency", 256'(cyc - t), 256'(expLat));
    tick();
    chk("settle_wrEnable", {255'b0, wrEnable_o}, 256'd0);
    chk("settle_busy", {255'b0, busy_o}, 256'd1);
    tick();
    chk("idle_busy", {255'b0, busy_o}, 256'd0);
    chk("idle_reqValid", {255'b0, memReqValid_o}, 256'd0);
    chk("handshakes", 256'(hsCount - hs0), 256'd1);
    chk("writes", 256'(wrCount - wr0), 256'd1);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] expAddr;
    int          rdyDly;
    int          g0, g1, g2, g3;
    int          expLat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{32'h0000_1234, 32'h0000_1220, 0, 0, 0, 0, 0, 6};
    vecs[1] = '{32'h2000_0ABC, 32'h2000_0AA0, 5, 0, 0, 0, 0, 11};
    vecs[2] = '{32'h0000_3FFF, 32'h0000_3FE0, 0, 0, 2, 0, 3, 11};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFE0, 1, 1, 0, 0, 0, 8};
    vecs[4] = '{32'h0000_0040, 32'h0000_0040, 0, 0, 0, 0, 0, 6};

    reset = 1'b1;
    miss_i = 1'b0;
    missAddr_i = '0;
    memReqReady_i = 1'b0;
    memRespValid_i = 1'b0;
    memRespData_i = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_reqValid", {255'b0, memReqValid_o}, 256'd0);
    chk("rst_reqAddr", {224'b0, memReqAddr_o}, 256'd0);
    chk("rst_wrEnable", {255'b0, wrEnable_o}, 256'd0);
    chk("rst_instBlock", instBlock_o, 256'd0);
    chk("rst_busy", {255'b0, busy_o}, 256'd0);
    chk("rst_protoErr", {255'b0, protoErr_o}, 256'd0);

    for (int i = 0; i < 5; i++) begin
      gapsA[0] = vecs[i].g0;
      gapsA[1] = vecs[i].g1;
      gapsA[2] = vecs[i].g2;
      gapsA[3] = vecs[i].g3;
      for (int k = 0; k < 4; k++) dataA[k] = {16{4'(k + 1 + i)}};
      doRefill(vecs[i].addr, vecs[i].expAddr, vecs[i].rdyDly, vecs[i].expLat, 1'b0);
      chk("no_protoErr", {255'b0, protoErr_o}, 256'd0);
    end

    // Miss held high: SETTLE must not sample it; second request only from IDLE.
    for (int k = 0; k < 4; k++) begin gapsA[k] = 0; dataA[k] = {8{8'hA0 + 8'(k)}}; end
    doRefill(32'h0000_0517, 32'h0000_0500, 0, 6, 1'b1);
    for (int k = 0; k < 4; k++) dataA[k] = {8{8'hB0 + 8'(k)}};
    doRefill(32'h0000_0528, 32'h0000_0520, 0, 6, 1'b1);
    miss_i = 1'b0;
    tick();

    // Stray beat in IDLE.
    begin
      int wr0;
      wr0 = wrCount;
      memRespValid_i = 1'b1;
      memRespData_i = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
      memRespValid_i = 1'b0;
      chk("perr_set", {255'b0, protoErr_o}, 256'd1);
      chk("perr_busy", {255'b0, busy_o}, 256'd0);
      tick();
      tick();
      chk("perr_sticky", {255'b0, protoErr_o}, 256'd1);
      chk("perr_nofill", 256'(wrCount - wr0), 256'd0);
      for (int k = 0; k < 4; k++) dataA[k] = {8{8'hC0 + 8'(k)}};
      doRefill(32'h0000_8000, 32'h0000_8000, 0, 6, 1'b0);
      chk("perr_after", {255'b0, protoErr_o}, 256'd1);
    end

    // Reset after two of four beats.
    begin
      int wr0;
      wr0 = wrCount;
      miss_i = 1'b1;
      missAddr_i = 32'h0000_1000;
      tick();
      miss_i = 1'b0;
      memReqReady_i = 1'b1;
      tick();
      memReqReady_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
        memRespValid_i = 1'b1;
        memRespData_i = {8{8'hE0 + 8'(k)}};
        tick();
      end
      memRespValid_i = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mrst_reqValid", {255'b0, memReqValid_o}, 256'd0);
      chk("mrst_reqAddr", {224'b0, memReqAddr_o}, 256'd0);
      chk("mrst_wrEnable", {255'b0, wrEnable_o}, 256'd0);
      chk("mrst_wrAddr", {224'b0, wrAddr_o}, 256'd0);
      chk("mrst_instBlock", instBlock_o, 256'd0);
      chk("mrst_busy", {255'b0, busy_o}, 256'd0);
      chk("mrst_protoErr", {255'b0, protoErr_o}, 256'd0);
      for (int i = 0; i < 6; i++) tick();
      chk("mrst_nowrite", 256'(wrCount - wr0), 256'd0);
      for (int k = 0; k < 4; k++) dataA[k] = {8{8'h50 + 8'(k)}};
      doRefill(32'h0000_0040, 32'h0000_0040, 0, 6, 1'b0);
    end

    // Randomized refills against the transaction-level model.
    for (int n = 0; n < 20; n++) begin
      logic [31:0] addr;
      int d, lat;
      bit hold;
      addr = $urandom;
      d = $urandom_range(0, 3);
      hold = 1'($urandom_range(0, 1));
      lat = 2 + 4 + d;
      for (int k = 0; k < 4; k++) begin
        gapsA[k] = $urandom_range(0, 2);
        dataA[k] = {$urandom, $urandom};
        lat += gapsA[k];
      end
      doRefill(addr, addr & ~32'd31, d, lat, hold);
    end
    miss_i = 1'b0;
    tick();
    chk("rand_protoErr", {255'b0, protoErr_o}, 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
